mig_cmd_queue: RTL and testbench

//  Parametrised request/response buffer between the APB-side requester and the MIG user interface.

---
 rtl/mig_cmd_queue_pkg.sv | 26 ++
 rtl/mig_cmd_queue_sync_fifo.sv | 59 +++++
 rtl/mig_cmd_queue.sv | 179 +++++++++++++++++
 tb/tb_mig_cmd_queue.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_cmd_queue_pkg.sv
// Shared types and constants for the MIG command queue.
// No logic: widths, issue FSM encodings and the command record.
// Consumers import with mig_cmd_queue_pkg::*.
package mig_cmd_queue_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  // Issue FSM encodings
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  // Command record at default widths; the queue builds the same layout from its own parameters
  typedef struct packed {
    logic                      we;
    logic [ADDR_W_DEF-1:0]     addr;
    logic [DATA_W_DEF-1:0]     data;
    logic [DATA_W_DEF/8-1:0]   strb;
  } mig_cmd_t;

  // Pointer width that stays legal for a single-entry FIFO
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mig_cmd_queue_sync_fifo.sv
// Generic first-word-fall-through FIFO of type T, DEPTH entries (any depth >= 1).
// Latency: push visible at pop_dat the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller watches full/empty.
module sync_fifo
  import mig_cmd_queue_pkg::*;
#(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  T                           push_dat,
  input  logic                       pop,
  output T                           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rptr];

  // Storage is data-only; validity lives in the pointers and count
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

  // Pointers wrap at DEPTH so non-power-of-two depths work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mig_cmd_queue.sv
// Buffers upstream read/write commands, issues them in order to MIG, returns read data in order.
// Latency: accept->mig_en_o 2 cycles, mig_valid_i->rsp_valid_o 1 cycle, back-to-back issue with no bubble.
// Backpressure: req_ready_o low when the command FIFO is full; reads held back while MAX_RD credits are used.
module mig_cmd_queue
  import mig_cmd_queue_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REQ_DEPTH = 4,
  parameter int MAX_RD    = 4
) (
  input  logic                         ui_clk_i,
  input  logic                         ui_reset_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [ADDR_W-1:0]            req_addr_i,
  input  logic [DATA_W-1:0]            req_data_i,
  input  logic [DATA_W/8-1:0]          req_strb_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DATA_W-1:0]            rsp_data_o,
  output logic                         mig_en_o,
  input  logic                         mig_ready_i,
  output logic                         mig_w_en_o,
  input  logic                         mig_w_ready_i,
  output logic                         mig_we_o,
  output logic [ADDR_W-1:0]            mig_addr_o,
  output logic [DATA_W-1:0]            mig_data_o,
  output logic [DATA_W/8-1:0]          mig_strb_o,
  input  logic                         mig_valid_i,
  input  logic [DATA_W-1:0]            mig_data_i,
  output logic [$clog2(MAX_RD+1)-1:0]  rd_pending_o,
  output logic                         err_o
);

  localparam int STRB_W = DATA_W/8;
  localparam int REQ_CW = $clog2(REQ_DEPTH+1);
  localparam int RSP_CW = $clog2(MAX_RD+1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  typedef logic [DATA_W-1:0] data_t;

  cmd_t              req_cmd;
  cmd_t              head;
  logic              cmd_push;
  logic              cmd_pop;
  logic              cmd_full;
  logic              cmd_empty;
  logic [REQ_CW-1:0] cmd_count;
  logic              unused_cmd_count;

  data_t             rsp_head;
  logic              rsp_push;
  logic              rsp_pop;
  logic              rsp_full;
  logic              rsp_empty;
  logic [RSP_CW-1:0] rsp_count;

  logic              state;
  logic              ready_en;
  logic              en_nxt;
  logic              w_en_nxt;
  logic              rd_issue;
  logic              rd_ret;
  logic              head_ok;
  logic              load;
  int                credit_used;

  assign req_cmd  = '{we: req_we_i, addr: req_addr_i, data: req_data_i, strb: req_strb_i};
  assign cmd_push = req_valid_i && req_ready_o;
  // Command FIFO occupancy is only needed through full/empty
  assign unused_cmd_count = ^cmd_count;

  sync_fifo #(.T(cmd_t), .DEPTH(REQ_DEPTH)) u_cmd_fifo (
    .clk      (ui_clk_i),
    .rst_n    (ui_reset_ni),
    .push     (cmd_push),
    .push_dat (req_cmd),
    .pop      (cmd_pop),
    .pop_dat  (head),
    .full     (cmd_full),
    .empty    (cmd_empty),
    .count    (cmd_count)
  );

  // Credits guarantee the response FIFO has room; the full guard is belt-and-braces
  assign rd_issue = mig_en_o && mig_ready_i && !mig_we_o;
  assign rd_ret   = mig_valid_i && (rd_pending_o != '0);
  assign rsp_push = rd_ret && !rsp_full;
  assign rsp_pop  = rsp_valid_o && rsp_ready_i;

  sync_fifo #(.T(data_t), .DEPTH(MAX_RD)) u_rsp_fifo (
    .clk      (ui_clk_i),
    .rst_n    (ui_reset_ni),
    .push     (rsp_push),
    .push_dat (mig_data_i),
    .pop      (rsp_pop),
    .pop_dat  (rsp_head),
    .full     (rsp_full),
    .empty    (rsp_empty),
    .count    (rsp_count)
  );

  assign req_ready_o = ready_en && !cmd_full;
  assign rsp_valid_o = !rsp_empty;
  assign rsp_data_o  = rsp_valid_o ? rsp_head : '0;

  // A read handshaking this edge already owns a credit even though rd_pending has not counted it yet
  assign credit_used = int'(rd_pending_o) + int'(rsp_count) + int'(rd_issue);

  // Decide whether the FIFO head moves into the output registers this edge
  always_comb begin
    en_nxt   = mig_en_o && !mig_ready_i;
    w_en_nxt = mig_w_en_o && !mig_w_ready_i;
    head_ok  = !cmd_empty && (head.we || (credit_used < MAX_RD));
    load     = 1'b0;
    if (state == ST_IDLE) load = head_ok;
    else                  load = !en_nxt && !w_en_nxt && head_ok;
  end

  assign cmd_pop = load;

  // Issue FSM with registered MIG command/write-data channels
  always_ff @(posedge ui_clk_i or negedge ui_reset_ni) begin
    if (!ui_reset_ni) begin
      state      <= ST_IDLE;
      mig_en_o   <= 1'b0;
      mig_w_en_o <= 1'b0;
      mig_we_o   <= 1'b0;
      mig_addr_o <= '0;
      mig_data_o <= '0;
      mig_strb_o <= '0;
    end else if (load) begin
      state      <= ST_ISSUE;
      mig_en_o   <= 1'b1;
      mig_w_en_o <= head.we;
      mig_we_o   <= head.we;
      mig_addr_o <= head.addr;
      mig_data_o <= head.data;
      mig_strb_o <= head.strb;
    end else if (state == ST_ISSUE) begin
      mig_en_o   <= en_nxt;
      mig_w_en_o <= w_en_nxt;
      if (!en_nxt && !w_en_nxt) state <= ST_IDLE;
    end
  end

  // Reads in flight: +1 on read command handshake, -1 on returned data
  always_ff @(posedge ui_clk_i or negedge ui_reset_ni) begin
    if (!ui_reset_ni) begin
      rd_pending_o <= '0;
    end else begin
      case ({rd_issue, rd_ret})
        2'b10:   rd_pending_o <= rd_pending_o + 1'b1;
        2'b01:   rd_pending_o <= rd_pending_o - 1'b1;
        default: rd_pending_o <= rd_pending_o;
      endcase
    end
  end

  // Sticky flag for read data nobody asked for; also holds off req_ready_o for one edge after reset
  always_ff @(posedge ui_clk_i or negedge ui_reset_ni) begin
    if (!ui_reset_ni) begin
      err_o    <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (mig_valid_i && (rd_pending_o == '0)) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mig_cmd_queue.sv
// Directed bench for mig_cmd_queue at default parameters.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// A passive monitor records the MIG command handshakes for order checks.
module tb_mig_cmd_queue;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int STRB_W = DATA_W/8;

  logic                ui_clk_i;
  logic                ui_reset_ni;
  logic                req_valid_i;
  logic                req_ready_o;
  logic                req_we_i;
  logic [ADDR_W-1:0]   req_addr_i;
  logic [DATA_W-1:0]   req_data_i;
  logic [STRB_W-1:0]   req_strb_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [DATA_W-1:0]   rsp_data_o;
  logic                mig_en_o;
  logic                mig_ready_i;
  logic                mig_w_en_o;
  logic                mig_w_ready_i;
  logic                mig_we_o;
  logic [ADDR_W-1:0]   mig_addr_o;
  logic [DATA_W-1:0]   mig_data_o;
  logic [STRB_W-1:0]   mig_strb_o;
  logic                mig_valid_i;
  logic [DATA_W-1:0]   mig_data_i;
  logic [2:0]          rd_pending_o;
  logic                err_o;

  int tests = 0;
  int fails = 0;
  logic [ADDR_W-1:0] rd_q[$];
  logic [ADDR_W-1:0] wr_q[$];

  mig_cmd_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REQ_DEPTH(4), .MAX_RD(4)) dut (
    .ui_clk_i      (ui_clk_i),
    .ui_reset_ni   (ui_reset_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
    .req_strb_i    (req_strb_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .mig_en_o      (mig_en_o),
    .mig_ready_i   (mig_ready_i),
    .mig_w_en_o    (mig_w_en_o),
    .mig_w_ready_i (mig_w_ready_i),
    .mig_we_o      (mig_we_o),
    .mig_addr_o    (mig_addr_o),
    .mig_data_o    (mig_data_o),
    .mig_strb_o    (mig_strb_o),
    .mig_valid_i   (mig_valid_i),
    .mig_data_i    (mig_data_i),
    .rd_pending_o  (rd_pending_o),
    .err_o         (err_o)
  );

  initial begin
    ui_clk_i = 1'b0;
    forever #5 ui_clk_i = ~ui_clk_i;
  end

  // Record every MIG command handshake in issue order
  always @(posedge ui_clk_i) begin
    if (mig_en_o && mig_ready_i) begin
      if (mig_we_o) wr_q.push_back(mig_addr_o);
      else          rd_q.push_back(mig_addr_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk_i);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rdata(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = {4'h0, a} ^ 32'hC0DE_0000;
    return {w, ~w, w, ~w};
  endfunction

  initial begin
    int n;
    int j;
    int ret;
    logic [DATA_W-1:0] a5;
    logic [DATA_W-1:0] d11;
    a5  = {16{8'hA5}};
    d11 = {16{8'h11}};

    // 1: reset and release
    ui_reset_ni   = 1'b0;
    req_valid_i   = 1'b0;
    req_we_i      = 1'b0;
    req_addr_i    = '0;
    req_data_i    = '0;
    req_strb_i    = '0;
    rsp_ready_i   = 1'b0;
    mig_ready_i   = 1'b1;
    mig_w_ready_i = 1'b1;
    mig_valid_i   = 1'b0;
    mig_data_i    = '0;
    #3;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_mig_en", mig_en_o, 0);
    chk("rst_mig_w_en", mig_w_en_o, 0);
    chk("rst_mig_addr", mig_addr_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rd_pending", rd_pending_o, 0);
    #9;
    ui_reset_ni = 1'b1;
    #1;
    chk("rel_ready_before_edge", req_ready_o, 0);
    tick();
    chk("rel_ready_after_edge", req_ready_o, 1);

    // 2: single write, both channels issue together 2 cycles after accept
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 28'h40;
    req_data_i  = a5;
    req_strb_i  = 16'hFFFF;
    tick();
    req_valid_i = 1'b0;
    chk("wr_en_not_yet", mig_en_o, 0);
    tick();
    chk("wr_en", mig_en_o, 1);
    chk("wr_w_en", mig_w_en_o, 1);
    chk("wr_we", mig_we_o, 1);
    chk("wr_addr", mig_addr_o, 28'h40);
    chk("wr_data", mig_data_o, a5);
    chk("wr_strb", mig_strb_o, 16'hFFFF);
    tick();
    chk("wr_en_drop", mig_en_o, 0);
    chk("wr_w_en_drop", mig_w_en_o, 0);
    chk("wr_no_rsp", rsp_valid_o, 0);

    // 3: write data channel stalled, next command (a read) waits for it
    mig_w_ready_i = 1'b0;
    req_valid_i   = 1'b1;
    req_we_i      = 1'b1;
    req_addr_i    = 28'h80;
    req_data_i    = d11;
    req_strb_i    = 16'h00FF;
    tick();
    req_we_i   = 1'b0;
    req_addr_i = 28'h100;
    tick();
    req_valid_i = 1'b0;
    chk("ws_en", mig_en_o, 1);
    chk("ws_w_en", mig_w_en_o, 1);
    tick();
    chk("ws_en_dropped", mig_en_o, 0);
    chk("ws_w_en_held", mig_w_en_o, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ws_hold_w_en", mig_w_en_o, 1);
      chk("ws_hold_en", mig_en_o, 0);
      chk("ws_hold_data", mig_data_o, d11);
      chk("ws_hold_addr", mig_addr_o, 28'h80);
    end
    mig_w_ready_i = 1'b1;
    tick();
    chk("ws_next_en", mig_en_o, 1);
    chk("ws_next_w_en", mig_w_en_o, 0);
    chk("ws_next_we", mig_we_o, 0);
    chk("ws_next_addr", mig_addr_o, 28'h100);
    tick();
    chk("rd1_pending", rd_pending_o, 1);
    chk("rd1_en_drop", mig_en_o, 0);
    mig_valid_i = 1'b1;
    mig_data_i  = rdata(28'h100);
    tick();
    mig_valid_i = 1'b0;
    chk("rd1_rsp_valid", rsp_valid_o, 1);
    chk("rd1_rsp_data", rsp_data_o, rdata(28'h100));
    chk("rd1_pending_back", rd_pending_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("rd1_rsp_popped", rsp_valid_o, 0);

    // 4: read credit limit, 6 reads against MAX_RD=4
    rd_q.delete();
    for (int i = 0; i < 6; i++) begin
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_addr_i  = 28'h200 + 28'(16*i);
      n = 0;
      while (!req_ready_o && n < 50) begin
        tick();
        n++;
      end
      chk("cr_accept_bound", (n < 50), 1);
      tick();
    end
    req_valid_i = 1'b0;
    repeat (6) tick();
    chk("cr_issued4", rd_q.size(), 4);
    chk("cr_pending4", rd_pending_o, 4);
    for (int k = 0; k < 4; k++) begin
      mig_valid_i = 1'b1;
      mig_data_i  = rdata(rd_q[k]);
      tick();
    end
    mig_valid_i = 1'b0;
    repeat (3) tick();
    chk("cr_pending0", rd_pending_o, 0);
    chk("cr_still4", rd_q.size(), 4);
    chk("cr_rsp_valid", rsp_valid_o, 1);
    chk("cr_rsp0", rsp_data_o, rdata(28'h200));
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    repeat (4) tick();
    chk("cr_issued5", rd_q.size(), 5);
    chk("cr_fifth_addr", (rd_q.size() > 4) ? rd_q[4] : 28'h0, 28'h240);
    chk("cr_rsp1", rsp_data_o, rdata(28'h210));
    rsp_ready_i = 1'b1;
    j   = 1;
    ret = 4;
    for (int cyc = 0; cyc < 80 && j < 6; cyc++) begin
      if (rsp_valid_o) begin
        chk("cr_order", rsp_data_o, rdata(28'h200 + 28'(16*j)));
        j++;
      end
      if (ret < rd_q.size()) begin
        mig_valid_i = 1'b1;
        mig_data_i  = rdata(rd_q[ret]);
        ret++;
      end else begin
        mig_valid_i = 1'b0;
      end
      tick();
    end
    mig_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    chk("cr_all_returned", j, 6);
    chk("cr_err_clean", err_o, 0);

    // 5: fill the command FIFO while MIG is not ready
    mig_ready_i   = 1'b0;
    mig_w_ready_i = 1'b1;
    wr_q.delete();
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1;
      req_we_i    = 1'b1;
      req_addr_i  = 28'h300 + 28'(16*i);
      req_data_i  = DATA_W'(i);
      chk("fl_ready", req_ready_o, 1);
      tick();
    end
    req_addr_i = 28'h350;
    req_data_i = DATA_W'(5);
    chk("fl_full", req_ready_o, 0);
    tick();
    tick();
    chk("fl_stall", req_ready_o, 0);
    chk("fl_head_en", mig_en_o, 1);
    chk("fl_head_addr", mig_addr_o, 28'h300);
    mig_ready_i = 1'b1;
    tick();
    mig_ready_i = 1'b0;
    chk("fl_slot_free", req_ready_o, 1);
    chk("fl_next_addr", mig_addr_o, 28'h310);
    tick();
    req_valid_i = 1'b0;
    chk("fl_full_again", req_ready_o, 0);
    mig_ready_i = 1'b1;
    repeat (12) tick();
    chk("fl_wr_count", wr_q.size(), 6);
    chk("fl_wr_second", (wr_q.size() > 1) ? wr_q[1] : 28'h0, 28'h310);
    chk("fl_wr_last", (wr_q.size() > 5) ? wr_q[5] : 28'h0, 28'h350);

    // 6: unsolicited read data, then asynchronous reset mid-burst
    chk("er_pending0", rd_pending_o, 0);
    mig_valid_i = 1'b1;
    mig_data_i  = rdata(28'h999);
    tick();
    mig_valid_i = 1'b0;
    chk("er_set", err_o, 1);
    chk("er_no_rsp", rsp_valid_o, 0);
    repeat (3) tick();
    chk("er_sticky", err_o, 1);
    mig_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 28'h400;
    tick();
    req_addr_i = 28'h410;
    tick();
    req_valid_i = 1'b0;
    chk("ar_busy_en", mig_en_o, 1);
    #3;
    ui_reset_ni = 1'b0;
    #1;
    chk("ar_en", mig_en_o, 0);
    chk("ar_w_en", mig_w_en_o, 0);
    chk("ar_addr", mig_addr_o, 0);
    chk("ar_err", err_o, 0);
    chk("ar_ready", req_ready_o, 0);
    chk("ar_pending", rd_pending_o, 0);
    #2;
    ui_reset_ni = 1'b1;
    mig_ready_i = 1'b1;
    tick();
    tick();
    chk("ar_after_en", mig_en_o, 0);
    chk("ar_after_ready", req_ready_o, 1);
    chk("ar_after_err", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
